// File: rtl/enc_channel_ctrl.sv
// Shares one debounced rotary encoder among NUM_CH setpoint registers.
// Rotation steps the selected channel, short press selects the next one, long press clears it.
module enc_ch_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (ld) val_d = d;
  end

  always_ff @(posedge clk) begin
    if (rst) val_q <= '0;
    else     val_q <= val_d;
  end

  assign q = val_q;
endmodule

module enc_channel_ctrl #(
  parameter int NUM_CH     = 4,
  parameter int WIDTH      = 8,
  parameter int MAX        = 120,
  parameter int LONG_PRESS = 50000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      a_in,
  input  logic                      b_in,
  input  logic                      btn,
  output logic [$clog2(NUM_CH)-1:0] sel,
  output logic [WIDTH-1:0]          sel_val,
  output logic                      upd_valid,
  output logic [$clog2(NUM_CH)-1:0] upd_ch,
  output logic [WIDTH-1:0]          upd_val,
  input  logic                      upd_ready
);
  localparam int SEL_W = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(LONG_PRESS + 1);

  typedef enum logic [1:0] {IDLE, PRESS, HELD} st_t;

  st_t                            st_q, st_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [SEL_W-1:0]               sel_q, sel_d;
  logic [WIDTH-1:0]               sel_val_q, sel_val_d;
  logic                           a_q, btn_q;
  logic                           upd_valid_q, upd_valid_d;
  logic [SEL_W-1:0]               upd_ch_q, upd_ch_d;
  logic [WIDTH-1:0]               upd_val_q, upd_val_d;
  logic [NUM_CH-1:0][WIDTH-1:0]   ch_q;
  logic [NUM_CH-1:0]              ch_ld;
  logic [WIDTH-1:0]               cur, new_val;
  logic                           inc, dec, clr, step_ok, chg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      enc_ch_slot #(.WIDTH(WIDTH)) u_slot (
        .clk (clk),
        .rst (rst),
        .ld  (ch_ld[gi]),
        .d   (new_val),
        .q   (ch_q[gi])
      );
    end
  endgenerate

  always_comb begin
    inc   = a_in & ~a_q & ~b_in;
    dec   = a_in & ~a_q &  b_in;
    cur   = ch_q[sel_q];
    st_d  = st_q;
    cnt_d = cnt_q;
    sel_d = sel_q;
    clr   = 1'b0;
    case (st_q)
      IDLE: begin
        if (btn & ~btn_q) begin
          st_d  = PRESS;
          cnt_d = CNT_W'(1);
        end
      end
      PRESS: begin
        if (btn) begin
          cnt_d = cnt_q + CNT_W'(1);
          // Clear fires on the LONG_PRESS-th cycle the button is seen held.
          if (cnt_q >= CNT_W'(LONG_PRESS - 1)) begin
            clr  = 1'b1;
            st_d = HELD;
          end
        end else begin
          st_d  = IDLE;
          sel_d = (sel_q == SEL_W'(NUM_CH - 1)) ? '0 : sel_q + SEL_W'(1);
        end
      end
      HELD: begin
        if (!btn) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase

    // Step and clear both target the pre-edge selection; clear takes priority.
    step_ok = (inc & (cur != WIDTH'(MAX))) | (dec & (cur != '0));
    new_val = clr ? '0 : (inc ? cur + WIDTH'(1) : cur - WIDTH'(1));
    chg     = clr | step_ok;
    ch_ld   = '0;
    if (chg) ch_ld[sel_q] = 1'b1;

    upd_valid_d = chg | (upd_valid_q & ~upd_ready);
    upd_ch_d    = chg ? sel_q   : upd_ch_q;
    upd_val_d   = chg ? new_val : upd_val_q;
    sel_val_d   = cur;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= IDLE;
      cnt_q       <= '0;
      sel_q       <= '0;
      sel_val_q   <= '0;
      a_q         <= a_in;
      btn_q       <= btn;
      upd_valid_q <= 1'b0;
      upd_ch_q    <= '0;
      upd_val_q   <= '0;
    end else begin
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      sel_val_q   <= sel_val_d;
      a_q         <= a_in;
      btn_q       <= btn;
      upd_valid_q <= upd_valid_d;
      upd_ch_q    <= upd_ch_d;
      upd_val_q   <= upd_val_d;
    end
  end

  assign sel       = sel_q;
  assign sel_val   = sel_val_q;
  assign upd_valid = upd_valid_q;
  assign upd_ch    = upd_ch_q;
  assign upd_val   = upd_val_q;
endmodule

// File: tb/tb_enc_channel_ctrl.sv
// Directed plus randomized bench for enc_channel_ctrl against a cycle-level reference model.
module tb_enc_channel_ctrl;
  localparam int NCH = 4;
  localparam int W   = 8;
  localparam int MX  = 120;
  localparam int LP  = 8;

  logic         clk = 1'b0;
  logic         rst, a, b, bt, rdy;
  logic [1:0]   sel, upd_ch;
  logic [W-1:0] sel_val, upd_val;
  logic         upd_valid;

  int n_assert = 0, n_fail = 0, n_upd = 0;
  int m_ch[NCH];
  int m_sel, m_mode, m_len, m_pend, m_uch, m_uval, m_pa, m_pb, exp_sv;

  enc_channel_ctrl #(.NUM_CH(NCH), .WIDTH(W), .MAX(MX), .LONG_PRESS(LP)) dut (
    .clk(clk), .rst(rst), .a_in(a), .b_in(b), .btn(bt),
    .sel(sel), .sel_val(sel_val), .upd_valid(upd_valid),
    .upd_ch(upd_ch), .upd_val(upd_val), .upd_ready(rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: channels as plain integers, press tracked as a held-cycle count.
  task automatic model_edge();
    int step, nv, osel;
    bit clear, changed;
    if (rst) begin
      foreach (m_ch[i]) m_ch[i] = 0;
      m_sel = 0; m_mode = 0; m_len = 0; m_pend = 0; m_uch = 0; m_uval = 0; exp_sv = 0;
      m_pa = a; m_pb = bt;
      return;
    end
    exp_sv  = m_ch[m_sel];
    step    = (a && !m_pa) ? (b ? -1 : 1) : 0;
    clear   = 0;
    changed = 0;
    nv      = 0;
    osel    = m_sel;
    if (m_mode == 0) begin
      if (bt && !m_pb) begin m_mode = 1; m_len = 1; end
    end else if (m_mode == 1) begin
      if (bt) begin
        m_len++;
        if (m_len == LP) begin clear = 1; m_mode = 2; end
      end else begin
        m_sel = (m_sel + 1) % NCH;
        m_mode = 0;
      end
    end else if (!bt) m_mode = 0;
    if (clear) begin
      m_ch[osel] = 0; changed = 1; nv = 0;
    end else if (step != 0) begin
      nv = m_ch[osel] + step;
      if (nv >= 0 && nv <= MX) begin m_ch[osel] = nv; changed = 1; end
    end
    if (changed) begin m_pend = 1; m_uch = osel; m_uval = nv; end
    else if (m_pend && rdy) m_pend = 0;
    m_pa = a; m_pb = bt;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("sel", int'(sel), m_sel);
    chk("sel_val", int'(sel_val), exp_sv);
    chk("upd_valid", int'(upd_valid), m_pend);
    if (m_pend == 1) begin
      chk("upd_ch", int'(upd_ch), m_uch);
      chk("upd_val", int'(upd_val), m_uval);
    end
    if (upd_valid === 1'b1) n_upd++;
  endtask

  task automatic step(input logic dir);
    b = dir; a = 1'b1; cyc();
    a = 1'b0; cyc();
  endtask

  task automatic press(input int n);
    bt = 1'b1;
    repeat (n) cyc();
    bt = 1'b0; cyc();
  endtask

  initial begin
    int found;
    rst = 1'b1; a = 1'b0; b = 1'b0; bt = 1'b0; rdy = 1'b1;
    cyc(); cyc();
    chk("rst_upd_ch", int'(upd_ch), 0);
    chk("rst_upd_val", int'(upd_val), 0);
    rst = 1'b0; cyc();

    // Five CW steps on ch0
    n_upd = 0;
    for (int i = 0; i < 5; i++) step(1'b0);
    chk("t1_val", int'(sel_val), 5);
    chk("t1_updates", n_upd, 5);

    // Saturation at MAX and at 0
    repeat (113) step(1'b0);
    n_upd = 0;
    repeat (4) step(1'b0);
    chk("t2_max_updates", n_upd, 2);
    chk("t2_max_val", int'(sel_val), 120);
    press(3);
    n_upd = 0;
    repeat (2) step(1'b1);
    chk("t2_zero_updates", n_upd, 0);
    chk("t2_zero_val", int'(sel_val), 0);

    // Short presses walk and wrap the selection
    for (int k = 1; k <= 7; k++) begin
      press(3);
      chk("t3_sel", int'(sel), (1 + k) % NCH);
    end

    // Long press clears ch0 (currently 120) after LP held cycles
    bt = 1'b1; cyc();
    found = -1;
    for (int i = 1; i < 20; i++) begin
      cyc();
      if (found < 0 && upd_valid === 1'b1) found = i;
    end
    bt = 1'b0; cyc(); cyc();
    chk("t4_clear_lat", found, LP - 1);
    chk("t4_val", int'(sel_val), 0);
    chk("t4_sel", int'(sel), 0);

    // Backpressure and coalescing
    repeat (10) step(1'b0);
    rdy = 1'b0;
    repeat (3) step(1'b0);
    chk("t5_pend", int'(upd_valid), 1);
    chk("t5_pend_val", int'(upd_val), 13);
    rdy = 1'b1; b = 1'b0; a = 1'b1; cyc();
    chk("t5_coalesce_valid", int'(upd_valid), 1);
    chk("t5_coalesce_val", int'(upd_val), 14);
    a = 1'b0; cyc();
    chk("t5_drain", int'(upd_valid), 0);

    // Clear beats a simultaneous CW step
    bt = 1'b1; cyc();
    repeat (LP - 2) cyc();
    a = 1'b1; cyc();
    chk("t6_clear_wins", int'(upd_val), 0);
    a = 1'b0; bt = 1'b0; cyc(); cyc();
    chk("t6_val", int'(sel_val), 0);

    // Reset in the middle of a press
    press(3);
    bt = 1'b1; cyc(); cyc();
    rst = 1'b1; cyc();
    chk("t6_rst_sel", int'(sel), 0);
    chk("t6_rst_valid", int'(upd_valid), 0);
    rst = 1'b0; cyc();
    bt = 1'b0; cyc(); cyc();
    chk("t6_no_sel_change", int'(sel), 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      a   = 1'($urandom_range(0, 1));
      b   = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 14) == 0) bt = ~bt;
      rst = ($urandom_range(0, 799) == 0);
      cyc();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
